// File: rtl/dart_disp_pkg.sv
// Shared widths, FSM states, last-player tags and seven-segment codes
// for the dart score display.
package dart_disp_pkg;
  localparam int PT_W       = 9;
  localparam int NUM_DIGITS = 6;
  localparam int BCD_DIGITS = 3;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV1  = 2'd1,
    ST_CONV2  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    LAST_NONE = 2'd0,
    LAST_P1   = 2'd1,
    LAST_P2   = 2'd2
  } last_e;

  // Active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/bin2bcd_serial.sv
// Serial double-dabble: the start cycle performs the first of PT_W add-3/shift
// iterations; done pulses for one cycle after the last, and bcd then holds.
module bin2bcd_serial
  import dart_disp_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PT_W-1:0]  bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);
  logic [BCD_W-1:0] bcd_r, src_bcd_s, adj_s, next_bcd_s;
  logic [PT_W-1:0]  bin_r, src_bin_s, next_bin_s;
  logic [3:0]       cnt_r;
  logic             done_r;

  function automatic logic [3:0] add3(input logic [3:0] d);
    if (d >= 4'd5) begin
      add3 = d + 4'd3;
    end else begin
      add3 = d;
    end
  endfunction

  // One add-3-then-shift step; a start restarts from a cleared accumulator.
  always_comb begin
    src_bcd_s = start ? {BCD_W{1'b0}} : bcd_r;
    src_bin_s = start ? bin : bin_r;
    adj_s     = {BCD_W{1'b0}};
    for (int i = 0; i < BCD_DIGITS; i++) begin
      adj_s[4*i +: 4] = add3(src_bcd_s[4*i +: 4]);
    end
    next_bcd_s = {adj_s[BCD_W-2:0], src_bin_s[PT_W-1]};
    next_bin_s = {src_bin_s[PT_W-2:0], 1'b0};
  end

  // Iteration state and completion pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcd_r  <= {BCD_W{1'b0}};
      bin_r  <= {PT_W{1'b0}};
      cnt_r  <= 4'd0;
      done_r <= 1'b0;
    end else if (start) begin
      bcd_r  <= next_bcd_s;
      bin_r  <= next_bin_s;
      cnt_r  <= 4'(PT_W - 1);
      done_r <= 1'b0;
    end else if (cnt_r != 4'd0) begin
      bcd_r  <= next_bcd_s;
      bin_r  <= next_bin_s;
      cnt_r  <= cnt_r - 4'd1;
      done_r <= (cnt_r == 4'd1);
    end else begin
      done_r <= 1'b0;
    end
  end

  assign bcd  = bcd_r;
  assign done = done_r;
endmodule

// File: rtl/dart_score_display.sv
// Converts both players' totals to BCD and scans them onto a 6-digit
// active-low seven-segment display, blinking the winner after game over.
module dart_score_display
  import dart_disp_pkg::*;
#(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  game_set_i,
  input  logic                  player_1_done_i,
  input  logic                  player_2_done_i,
  input  logic                  player_1_win_i,
  input  logic                  player_2_win_i,
  input  logic [PT_W-1:0]       player_1_pt_i,
  input  logic [PT_W-1:0]       player_2_pt_i,
  output logic [6:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic                  dp_o,
  output logic                  busy_o
);
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int FR_W  = $clog2(BLINK_DIV + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
  localparam logic [FR_W-1:0]  FR_MAX  = FR_W'(BLINK_DIV - 1);

  state_e                state_r;
  last_e                 last_r;
  logic                  busy_r, pending_r, game_set_d_r, blink_r, dp_r;
  logic [PT_W-1:0]       snap2_r;
  logic [BCD_W-1:0]      hold1_r, disp1_r, disp2_r;
  logic [2:0]            idx_r;
  logic [DIV_W-1:0]      div_r;
  logic [FR_W-1:0]       frame_r;
  logic [6:0]            seg_r;
  logic [NUM_DIGITS-1:0] an_r;

  logic                  req_s, gs_fall_s, scan_wrap_s, frame_wrap_s;
  logic                  conv_start_s, conv_done_s, blank_s, blink_s, dp_on_s;
  logic [PT_W-1:0]       conv_bin_s;
  logic [BCD_W-1:0]      conv_bcd_s, sel_bcd_s;
  logic [3:0]            digit_s;

  assign req_s        = player_1_done_i | player_2_done_i | (game_set_i & ~game_set_d_r);
  assign gs_fall_s    = ~game_set_i & game_set_d_r;
  assign scan_wrap_s  = (div_r == DIV_MAX);
  assign frame_wrap_s = scan_wrap_s && (idx_r == 3'd5);
  // Player 1 is fed live at the start edge (it is the snapshot); player 2 from its latch.
  assign conv_start_s = ((state_r == ST_IDLE) && (req_s || pending_r)) ||
                        ((state_r == ST_CONV1) && conv_done_s);
  assign conv_bin_s   = (state_r == ST_IDLE) ? player_1_pt_i : snap2_r;

  bin2bcd_serial u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start_s),
    .bin   (conv_bin_s),
    .bcd   (conv_bcd_s),
    .done  (conv_done_s)
  );

  // Conversion sequencer: IDLE -> CONV1 -> CONV2 -> COMMIT, coalescing requests into pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      pending_r <= 1'b0;
      snap2_r   <= {PT_W{1'b0}};
      hold1_r   <= {BCD_W{1'b0}};
      disp1_r   <= {BCD_W{1'b0}};
      disp2_r   <= {BCD_W{1'b0}};
    end else begin
      if (req_s && (state_r != ST_IDLE)) pending_r <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          if (req_s || pending_r) begin
            snap2_r   <= player_2_pt_i;
            pending_r <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= ST_CONV1;
          end
        end
        ST_CONV1: begin
          if (conv_done_s) begin
            hold1_r <= conv_bcd_s;
            state_r <= ST_CONV2;
          end
        end
        ST_CONV2: begin
          if (conv_done_s) state_r <= ST_COMMIT;
        end
        ST_COMMIT: begin
          disp1_r <= hold1_r;
          disp2_r <= conv_bcd_s;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Scan divider, digit index, frame counter and blink phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_r   <= {DIV_W{1'b0}};
      idx_r   <= 3'd0;
      frame_r <= {FR_W{1'b0}};
      blink_r <= 1'b0;
    end else begin
      if (scan_wrap_s) begin
        div_r <= {DIV_W{1'b0}};
        idx_r <= (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
      end else begin
        div_r <= div_r + DIV_W'(1);
      end
      if (gs_fall_s) begin
        frame_r <= {FR_W{1'b0}};
        blink_r <= 1'b0;
      end else if (frame_wrap_s) begin
        if (frame_r == FR_MAX) begin
          frame_r <= {FR_W{1'b0}};
          blink_r <= ~blink_r;
        end else begin
          frame_r <= frame_r + FR_W'(1);
        end
      end
    end
  end

  // Game-set edge history and last player to finish a turn.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_set_d_r <= 1'b0;
      last_r       <= LAST_NONE;
    end else begin
      game_set_d_r <= game_set_i;
      if (gs_fall_s)            last_r <= LAST_NONE;
      else if (player_2_done_i) last_r <= LAST_P2;
      else if (player_1_done_i) last_r <= LAST_P1;
    end
  end

  // Digit selection with leading-zero blanking and blink masking.
  always_comb begin
    sel_bcd_s = (idx_r >= 3'd3) ? disp2_r : disp1_r;
    digit_s   = 4'd0;
    blank_s   = 1'b1;
    case (idx_r)
      3'd0, 3'd3: begin
        digit_s = sel_bcd_s[3:0];
        blank_s = 1'b0;
      end
      3'd1, 3'd4: begin
        digit_s = sel_bcd_s[7:4];
        blank_s = (sel_bcd_s[11:8] == 4'd0) && (sel_bcd_s[7:4] == 4'd0);
      end
      3'd2, 3'd5: begin
        digit_s = sel_bcd_s[11:8];
        blank_s = (sel_bcd_s[11:8] == 4'd0);
      end
      default: begin
        digit_s = 4'd0;
        blank_s = 1'b1;
      end
    endcase
    blink_s = game_set_i & blink_r & ((idx_r >= 3'd3) ? player_2_win_i : player_1_win_i);
    dp_on_s = ((last_r == LAST_P1) && (idx_r == 3'd0)) ||
              ((last_r == LAST_P2) && (idx_r == 3'd3));
  end

  // Registered display drive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_r <= SEG_BLANK;
      an_r  <= {NUM_DIGITS{1'b1}};
      dp_r  <= 1'b1;
    end else if (blink_s) begin
      seg_r <= SEG_BLANK;
      an_r  <= {NUM_DIGITS{1'b1}};
      dp_r  <= 1'b1;
    end else begin
      seg_r <= blank_s ? SEG_BLANK : seg_code(digit_s);
      an_r  <= ~(NUM_DIGITS'(1) << idx_r);
      dp_r  <= ~dp_on_s;
    end
  end

  assign seg_o  = seg_r;
  assign an_o   = an_r;
  assign dp_o   = dp_r;
  assign busy_o = busy_r;
endmodule

// File: tb/tb_dart_score_display.sv
// Directed bench for dart_score_display with SCAN_DIV=4, BLINK_DIV=2:
// conversion latency, coalescing, blanking, decimal point and winner blink.
module tb_dart_score_display;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       game_set = 1'b0, p1_done = 1'b0, p2_done = 1'b0;
  logic       p1_win = 1'b0, p2_win = 1'b0;
  logic [8:0] p1_pt = 9'd0, p2_pt = 9'd0;
  logic [6:0] seg;
  logic [5:0] an;
  logic       dp, busy;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ecnt;

  dart_score_display #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .game_set_i      (game_set),
    .player_1_done_i (p1_done),
    .player_2_done_i (p2_done),
    .player_1_win_i  (p1_win),
    .player_2_win_i  (p2_win),
    .player_1_pt_i   (p1_pt),
    .player_2_pt_i   (p2_pt),
    .seg_o           (seg),
    .an_o            (an),
    .dp_o            (dp),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  // Edges since the last reset release; drives the scan/blink reference.
  always @(posedge clk or negedge reset) begin
    if (!reset) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic pulse(input logic d1, input logic d2);
    p1_done = d1;
    p2_done = d2;
    @(negedge clk);
    p1_done = 1'b0;
    p2_done = 1'b0;
  endtask

  task automatic wait_idle(output int hi);
    hi = 0;
    for (int c = 0; c < 100; c++) begin
      if (busy !== 1'b1) break;
      hi++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic wait_digit(input int idx, output logic [6:0] s, output logic d, output bit found);
    logic [5:0] pat;
    pat   = ~(6'd1 << idx);
    found = 1'b0;
    s     = 7'h00;
    d     = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (an === pat) begin
        found = 1'b1;
        s     = seg;
        d     = dp;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL reset_seg: got %h want 7f", seg); end
    n_cmp++; if (an !== 6'h3F) begin n_bad++; $display("FAIL reset_an: got %h want 3f", an); end
    n_cmp++; if (dp !== 1'b1) begin n_bad++; $display("FAIL reset_dp: got %b want 1", dp); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [6:0] es [6];
    logic       ed [6];
    logic [6:0] s;
    logic       d;
    bit         ok;
    int         hi;
    es = '{7'h78, 7'h30, 7'h79, 7'h12, 7'h19, 7'h7F};
    ed = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    p1_pt = 9'd137; p2_pt = 9'd45;
    pulse(1'b1, 1'b0);
    wait_idle(hi);
    n_cmp++; if (hi != 19) begin n_bad++; $display("FAIL basic_busy_len: got %0d want 19", hi); end
    for (int i = 0; i < 6; i++) begin
      wait_digit(i, s, d, ok);
      n_cmp++;
      if (!ok || s !== es[i] || d !== ed[i]) begin
        n_bad++;
        $display("FAIL basic_digit%0d: got seg=%h dp=%b seen=%0d want seg=%h dp=%b", i, s, d, ok, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] es [6];
    logic [6:0] s;
    logic       d;
    bit         ok;
    es = '{7'h40, 7'h7F, 7'h7F, 7'h40, 7'h7F, 7'h7F};
    p1_pt = 9'd300; p2_pt = 9'd200;
    pulse(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", busy); end
    n_cmp++; if (an !== 6'h3F) begin n_bad++; $display("FAIL midreset_an: got %h want 3f", an); end
    n_cmp++; if (seg !== 7'h7F) begin n_bad++; $display("FAIL midreset_seg: got %h want 7f", seg); end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_digit(i, s, d, ok);
      n_cmp++;
      if (!ok || s !== es[i] || d !== 1'b1) begin
        n_bad++;
        $display("FAIL midreset_digit%0d: got seg=%h dp=%b seen=%0d want seg=%h dp=1", i, s, d, ok, es[i]);
      end
    end
  endtask

  task automatic test_coalesce();
    logic       bv [80];
    logic [6:0] es [6];
    logic       ed [6];
    logic [6:0] s;
    logic       d;
    bit         ok;
    int         sum;
    es = '{7'h02, 7'h12, 7'h24, 7'h12, 7'h40, 7'h30};
    ed = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    p1_pt = 9'd10; p2_pt = 9'd20;
    pulse(1'b1, 1'b0);
    sum = 0;
    for (int c = 0; c < 80; c++) begin
      bv[c] = busy;
      if (busy === 1'b1) sum++;
      if (c == 2) begin p2_done = 1'b1; p1_pt = 9'd250; p2_pt = 9'd99; end
      if (c == 3) p2_done = 1'b0;
      if (c == 6) begin p1_done = 1'b1; p1_pt = 9'd256; p2_pt = 9'd305; end
      if (c == 7) p1_done = 1'b0;
      @(negedge clk);
    end
    n_cmp++; if (bv[18] !== 1'b1) begin n_bad++; $display("FAIL coal_busy18: got %b want 1", bv[18]); end
    n_cmp++; if (bv[19] !== 1'b0) begin n_bad++; $display("FAIL coal_busy19: got %b want 0", bv[19]); end
    n_cmp++; if (bv[20] !== 1'b1) begin n_bad++; $display("FAIL coal_busy20: got %b want 1", bv[20]); end
    n_cmp++; if (bv[39] !== 1'b0) begin n_bad++; $display("FAIL coal_busy39: got %b want 0", bv[39]); end
    n_cmp++; if (sum != 38) begin n_bad++; $display("FAIL coal_busy_total: got %0d want 38", sum); end
    for (int i = 0; i < 6; i++) begin
      wait_digit(i, s, d, ok);
      n_cmp++;
      if (!ok || s !== es[i] || d !== ed[i]) begin
        n_bad++;
        $display("FAIL coal_digit%0d: got seg=%h dp=%b seen=%0d want seg=%h dp=%b", i, s, d, ok, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_max_zero();
    logic [6:0] es [6];
    logic       ed [6];
    logic [6:0] s;
    logic       d;
    bit         ok;
    int         hi;
    es = '{7'h79, 7'h79, 7'h12, 7'h40, 7'h7F, 7'h7F};
    ed = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    p1_pt = 9'd511; p2_pt = 9'd0;
    pulse(1'b0, 1'b1);
    wait_idle(hi);
    n_cmp++; if (hi != 19) begin n_bad++; $display("FAIL max_busy_len: got %0d want 19", hi); end
    for (int i = 0; i < 6; i++) begin
      wait_digit(i, s, d, ok);
      n_cmp++;
      if (!ok || s !== es[i] || d !== ed[i]) begin
        n_bad++;
        $display("FAIL max_digit%0d: got seg=%h dp=%b seen=%0d want seg=%h dp=%b", i, s, d, ok, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_both_done();
    logic [6:0] es [6];
    logic       ed [6];
    logic [6:0] s;
    logic       d;
    bit         ok;
    int         hi, extra;
    es = '{7'h10, 7'h10, 7'h7F, 7'h78, 7'h7F, 7'h7F};
    ed = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    p1_pt = 9'd99; p2_pt = 9'd7;
    pulse(1'b1, 1'b1);
    wait_idle(hi);
    n_cmp++; if (hi != 19) begin n_bad++; $display("FAIL both_busy_len: got %0d want 19", hi); end
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      if (busy !== 1'b0) extra++;
      @(negedge clk);
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL both_single_conv: got %0d busy cycles want 0", extra); end
    for (int i = 0; i < 6; i++) begin
      wait_digit(i, s, d, ok);
      n_cmp++;
      if (!ok || s !== es[i] || d !== ed[i]) begin
        n_bad++;
        $display("FAIL both_digit%0d: got seg=%h dp=%b seen=%0d want seg=%h dp=%b", i, s, d, ok, es[i], ed[i]);
      end
    end
  endtask

  task automatic test_blink();
    int         m, ix, bl, hi, n_off;
    logic [5:0] ea;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    p1_pt = 9'd42; p2_pt = 9'd123;
    pulse(1'b1, 1'b0);
    wait_idle(hi);
    game_set = 1'b1;
    p2_win   = 1'b1;
    n_off    = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      m  = ecnt - 1;
      ix = (m / 4) % 6;
      bl = (m / 48) % 2;
      ea = (bl == 1 && ix >= 3) ? 6'h3F : ~(6'd1 << ix);
      if (ea == 6'h3F) n_off++;
      n_cmp++;
      if (an !== ea || (ea == 6'h3F && seg !== 7'h7F)) begin
        n_bad++;
        $display("FAIL blink_an at edge %0d: got an=%h seg=%h want an=%h", m, an, seg, ea);
      end
    end
    n_cmp++; if (n_off < 24) begin n_bad++; $display("FAIL blink_coverage: got %0d dark samples want >=24", n_off); end
    game_set = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      m  = ecnt - 1;
      ix = (m / 4) % 6;
      ea = ~(6'd1 << ix);
      n_cmp++;
      if (an !== ea || dp !== 1'b1) begin
        n_bad++;
        $display("FAIL unblink at edge %0d: got an=%h dp=%b want an=%h dp=1", m, an, dp, ea);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reset_mid();
    test_coalesce();
    test_max_zero();
    test_both_done();
    test_blink();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dart_score_display.md
Name: dart_score_display

Overview:
- Downstream consumer of the dart scoring core.
- Takes both players' 9-bit point totals and the done/win/game-set flags, converts the totals to BCD with a serial double-dabble converter, and drives a 6-digit multiplexed active-low seven-segment display.
- The winner's digits blink while game_set is asserted.

Parameters:
- SCAN_DIV, 1000, clocks each digit is held before the scan advances (≥2).
- BLINK_DIV, 8, full 6-digit scan frames per blink-phase toggle (≥1).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- game_set_i  input  1  game over; level signal
- player_1_done_i  input  1  one-cycle pulse: player 1 turn finished, pt updated
- player_2_done_i  input  1  one-cycle pulse: player 2 turn finished, pt updated
- player_1_win_i  input  1  player 1 won; valid while game_set_i=1
- player_2_win_i  input  1  player 2 won; valid while game_set_i=1
- player_1_pt_i  input  9  player 1 points, 0..511
- player_2_pt_i  input  9  player 2 points, 0..511
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low
- an_o  output  6  digit enables, active-low, one-hot
- dp_o  output  1  decimal point, active-low
- busy_o  output  1  BCD conversion in progress

Behaviour:
- Reset (reset=0, asynchronous) sets every register to its reset value; a conversion in flight is aborted and pending cleared.
  - seg_o=7'h7F, an_o=6'h3F, dp_o=1, busy_o=0.
  - BCD registers=0, digit index=0, divider=0, frame count=0, blink_phase=0, last_player=none, FSM=IDLE.
- Conversion request:
  - Raised by a player_1_done_i or player_2_done_i pulse, or by a rising edge of game_set_i.
  - Simultaneous sources form one request.
- FSM states: IDLE, CONV1, CONV2, COMMIT.
  - IDLE, request or pending at edge E0: snapshot both pt inputs, clear pending, go to CONV1.
  - CONV1: 9 add-3-then-shift iterations on player 1, one per clock. Then go to CONV2.
  - CONV2: 9 iterations on player 2. Then go to COMMIT.
  - COMMIT: write both 3-digit BCD results to the display registers, go to IDLE.
  - Display registers update at edge E0+19.
  - busy_o is registered: 1 from E0 through E0+19 exclusive, i.e. exactly 19 cycles.
- Request while busy sets pending; multiple requests coalesce to one.
  - In IDLE with pending=1, a new conversion starts on the next edge and takes a fresh snapshot.
- Max value 511 displays "511"; no saturation logic is needed.
- Digit map:
  - an index 0/1/2 = player 1 units/tens/hundreds.
  - an index 3/4/5 = player 2 units/tens/hundreds.
- Leading-zero blanking:
  - Hundreds digit blank if 0.
  - Tens digit blank if hundreds=0 and tens=0.
  - Units digit always shown, so 0 displays "0".
- Scan:
  - Divider counts 0..SCAN_DIV-1; at wrap the digit index increments 0..5, wrapping 5→0.
  - seg_o, an_o and dp_o are registered and follow the index with 1 cycle latency.
- Blink:
  - Frame counter increments on each index wrap 5→0; at BLINK_DIV frames it clears and toggles blink_phase.
  - While game_set_i=1, player_k_win_i=1 and blink_phase=1: player k's an bits are forced high and seg_o=7'h7F.
  - The loser's digits display steadily.
  - If both win flags are high, both players blink.
- last_player:
  - Set to 1 or 2 on that player's done pulse; both pulses together set 2.
  - dp_o=0 only while that player's units digit is enabled.
- Falling edge of game_set_i: blink_phase=0, frame count=0, last_player=none. BCD registers are retained.
- Segment codes, active-low gfedcba: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); blank=7F.

Decomposition:
- Package dart_disp_pkg holds:
  - PT_W=9, NUM_DIGITS=6, BCD_DIGITS=3.
  - FSM state enum.
  - Seven-segment code constants and SEG_BLANK.
- Sub-module bin2bcd_serial:
  - 9-bit double-dabble with start/done handshake, 9 cycles per conversion.
  - Instantiated once; the top sequences the two players through it.

Test Plan (SCAN_DIV=4, BLINK_DIV=2):
- Reset asserted mid-CONV1 → busy_o=0 immediately, an_o=3F, seg_o=7F; after release both players show "0" on index 0 and index 3.
- player_1_pt=137, player_2_pt=45, player_1_done pulse at E0 → busy_o high 19 cycles, then:
  - index 0/1/2 segs 78/30/79.
  - index 3/4 segs 12/19; index 5 blank (7F).
  - dp_o=0 on index 0 only.
- Done pulses at E0+3 and E0+7, pt changed after E0 → exactly one follow-up conversion starting when the first returns to IDLE; final display shows the latest pts.
- pt 511 and 0 → "511" on player 1, "0" on player 2; tens/hundreds of player 2 blank.
- game_set_i=1 with player_2_win_i=1 → player 2 an bits toggle off/on every 2 frames (48 clocks); player 1 steady; game_set_i falling → blinking stops and dp_o stays 1.
- player_1_done and player_2_done pulsed together → one conversion; dp_o lit on index 3.
